// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared PE scratchpad definitions: sequencer state encoding
//               and default filter spad geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int c_MEM_DEPTH = 224;
    localparam int c_OUT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Enabled up-counter that wraps to zero after limit-1 and
//               pulses o_wrap on the wrapping increment.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    assign o_wrap  = i_en && (r_count == i_limit - c_ONE);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr || o_wrap) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_read_seq.sv
`default_nettype none
// ============================================================================
// Module      : filter_read_seq
// Description : Filter spad read-address sequencer; walks the filter row
//               num_outs times and tags taps for the MAC. Optional stall
//               cycle counter enabled by FILTER_READ_SEQ_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_read_seq
    import pe_pkg::*;
#(
    parameter int MEM_DEPTH  = c_MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int OUT_WIDTH  = c_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] filt_len,
    input  logic [OUT_WIDTH-1:0]  num_outs,
    input  logic                  spad_full,
    input  logic                  mac_stall,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  tap_valid,
    output logic                  tap_first,
    output logic                  tap_last,
    output logic                  busy,
    output logic                  done
`ifdef FILTER_READ_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    seq_state_e            r_state;
    seq_state_e            w_next_state;

    logic [ADDR_WIDTH-1:0] r_filt_len;
    logic [OUT_WIDTH-1:0]  r_num_outs;
    logic [ADDR_WIDTH-1:0] w_len_clamped;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [OUT_WIDTH-1:0]  w_pass_unused;

    logic                  w_start_acc;
    logic                  w_issue;
    logic                  w_word_wrap;
    logic                  w_pass_wrap;
    logic                  w_tap_hold;

    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_first;
    logic                  r_rd_last;
    logic                  r_tap_valid;
    logic                  r_tap_first;
    logic                  r_tap_last;
    logic                  r_done;

    assign w_len_clamped = (32'(filt_len) > MEM_DEPTH) ? ADDR_WIDTH'(MEM_DEPTH) : filt_len;
    assign w_start_acc   = start && (r_state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ((w_len_clamped == '0) || (num_outs == '0)) ? DONE : WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (spad_full) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                // The pass counter only wraps on the word wrap of the last pass.
                if (w_pass_wrap) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        busy    = 1'b1;
        case (r_state)
            IDLE:    busy    = 1'b0;
            RUN:     w_issue = !mac_stall;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt_len <= '0;
            r_num_outs <= '0;
        end else if (w_start_acc) begin
            r_filt_len <= w_len_clamped;
            r_num_outs <= num_outs;
        end
    end

    wrap_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_word_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_start_acc),
        .i_en    (w_issue),
        .i_limit (r_filt_len),
        .o_count (w_word),
        .o_wrap  (w_word_wrap)
    );

    wrap_counter #(
        .WIDTH (OUT_WIDTH)
    ) u_pass_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_start_acc),
        .i_en    (w_word_wrap),
        .i_limit (r_num_outs),
        .o_count (w_pass_unused),
        .o_wrap  (w_pass_wrap)
    );

    // r_addr follows the frozen word counter while stalled, so it parks on
    // the next address to be issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_en    <= w_issue;
            r_rd_first <= w_issue && (w_word == '0);
            r_rd_last  <= w_word_wrap;
            if (r_state == RUN) begin
                r_rd_addr <= w_word;
            end
        end
    end

    // A read already in flight is still captured; otherwise the presented tap
    // is held for as long as the MAC stalls.
    assign w_tap_hold = (r_state == RUN) && mac_stall && !r_rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap_valid <= 1'b0;
            r_tap_first <= 1'b0;
            r_tap_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (!w_tap_hold) begin
                r_tap_valid <= r_rd_en;
                r_tap_first <= r_rd_first;
                r_tap_last  <= r_rd_last;
            end
        end
    end

`ifdef FILTER_READ_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == RUN) && mac_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

    assign r_en      = r_rd_en;
    assign r_addr    = r_rd_addr;
    assign tap_valid = r_tap_valid;
    assign tap_first = r_tap_first;
    assign tap_last  = r_tap_last;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_filter_read_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_read_seq
// Description : Self-checking bench for filter_read_seq (vector table plus
//               read/tap scoreboard and multi-cycle corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_filter_read_seq;
    import pe_pkg::*;

    localparam int AW = $clog2(c_MEM_DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] filt_len = '0;
    logic [7:0]    num_outs = '0;
    logic          spad_full = 1'b1;
    logic          mac_stall = 1'b0;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic          tap_valid;
    logic          tap_first;
    logic          tap_last;
    logic          busy;
    logic          done;
`ifdef FILTER_READ_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    filter_read_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .filt_len  (filt_len),
        .num_outs  (num_outs),
        .spad_full (spad_full),
        .mac_stall (mac_stall),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .tap_valid (tap_valid),
        .tap_first (tap_first),
        .tap_last  (tap_last),
        .busy      (busy),
        .done      (done)
`ifdef FILTER_READ_SEQ_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          first;
        logic          last;
    } rd_t;

    typedef struct {
        int fl;
        int no;
        int reads;
        int lat;
    } vec_t;

    rd_t  q_rd[$];
    rd_t  q_tap[$];
    int   total = 0;
    int   bad = 0;
    int   rd_seen = 0;
    int   done_seen = 0;
    logic prev_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input int fl, input int no);
        int  len;
        rd_t e;
        len = (fl > c_MEM_DEPTH) ? c_MEM_DEPTH : fl;
        for (int p = 0; p < no; p++) begin
            for (int w = 0; w < len; w++) begin
                e.addr  = AW'(w);
                e.first = (w == 0);
                e.last  = (w == len - 1);
                q_rd.push_back(e);
                q_tap.push_back(e);
            end
        end
    endtask

    task automatic wait_done(output int lat, input int lat0);
        lat = lat0;
        while (!done && lat < 2000) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic run_job(input int fl, input int no, output int lat);
        push_model(fl, no);
        filt_len = AW'(fl);
        num_outs = 8'(no);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(lat, 1);
    endtask

    // Scoreboard: every issued read and every tap following a read.
    always @(posedge clk) begin
        rd_t e;
        #3;
        if (!reset) begin
            prev_en = 1'b0;
        end else begin
            if (done) done_seen++;
            if (prev_en) begin
                check("tap_expected", (q_tap.size() != 0), 1);
                if (q_tap.size() != 0) begin
                    e = q_tap.pop_front();
                    check("tap_flags", {tap_valid, tap_first, tap_last}, {1'b1, e.first, e.last});
                end
            end
            if (r_en) begin
                rd_seen++;
                check("read_expected", (q_rd.size() != 0), 1);
                if (q_rd.size() != 0) begin
                    e = q_rd.pop_front();
                    check("rd_addr", r_addr, e.addr);
                end
            end
            prev_en = r_en;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   lat;
        int   r0;
        int   d0;
        int   n;

        vecs[0] = '{fl: 3,   no: 2, reads: 6,   lat: 9};
        vecs[1] = '{fl: 1,   no: 3, reads: 3,   lat: 6};
        vecs[2] = '{fl: 4,   no: 1, reads: 4,   lat: 7};
        vecs[3] = '{fl: 0,   no: 4, reads: 0,   lat: 2};
        vecs[4] = '{fl: 5,   no: 0, reads: 0,   lat: 2};
        vecs[5] = '{fl: 2,   no: 2, reads: 4,   lat: 7};
        vecs[6] = '{fl: 250, no: 1, reads: 224, lat: 227};

        repeat (3) tick();
        check("reset_outputs", {r_en, r_addr, tap_valid, tap_first, tap_last, busy, done}, '0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            r0 = rd_seen;
            run_job(vecs[i].fl, vecs[i].no, lat);
            check($sformatf("vec%0d_done_latency", i), lat, vecs[i].lat);
            tick();
            check($sformatf("vec%0d_reads", i), rd_seen - r0, vecs[i].reads);
            check($sformatf("vec%0d_queue_empty", i), q_rd.size(), 0);
            check($sformatf("vec%0d_idle", i), {busy, r_en}, 2'b00);
        end

        // Fill wait, with an ignored start and spad_full dropping mid-run.
        spad_full = 1'b0;
        r0 = rd_seen;
        push_model(2, 1);
        filt_len = AW'(2);
        num_outs = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("wait_fill_hold", {r_en, busy}, 2'b01);
            if (i == 4) begin
                start    = 1'b1;
                filt_len = AW'(7);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        spad_full = 1'b1;
        tick();
        check("fill_first_cycle", r_en, 0);
        tick();
        check("fill_first_read", {r_en, r_addr}, {1'b1, AW'(0)});
        spad_full = 1'b0;
        wait_done(lat, 0);
        check("fill_done_seen", (lat >= 0), 1);
        tick();
        check("fill_reads", rd_seen - r0, 2);
        spad_full = 1'b1;

        // Three-cycle MAC stall when the word counter sits at 2.
        push_model(4, 1);
        filt_len = AW'(4);
        num_outs = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        mac_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) mac_stall = 1'b0;
            check("stall_rd_hold", {r_en, r_addr}, {1'b0, AW'(2)});
            check("stall_tap_hold", {tap_valid, tap_first, tap_last}, 3'b100);
        end
        tick();
        check("stall_resume_rd", {r_en, r_addr, tap_valid}, {1'b1, AW'(2), 1'b0});
        tick();
        check("stall_last_rd", {r_en, r_addr}, {1'b1, AW'(3)});
        tick();
        check("stall_done", done, 1);
`ifdef FILTER_READ_SEQ_STALL_CNT_EN
        check("stall_cycles", stall_cycles, 3);
`endif
        tick();

        // Reset asserted at the fourth read of a 5x2 job.
        push_model(5, 2);
        filt_len = AW'(5);
        num_outs = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FILTER_READ_SEQ_STALL_CNT_EN
        check("stall_cycles_clear", stall_cycles, 0);
`endif
        n = 0;
        while (!(r_en && r_addr == AW'(3)) && n < 50) begin
            tick();
            n++;
        end
        check("reset_found_4th_read", (n < 50), 1);
        #1;
        reset = 1'b0;
        #1;
        check("reset_mid_job", {r_en, r_addr, tap_valid, tap_first, tap_last, busy, done}, '0);
        q_rd.delete();
        q_tap.delete();
        d0 = done_seen;
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("reset_no_done", done_seen - d0, 0);
        r0 = rd_seen;
        run_job(5, 2, lat);
        check("rerun_done_latency", lat, 13);
        tick();
        check("rerun_reads", rd_seen - r0, 10);
        check("rerun_queue_empty", q_rd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_read_seq.md
Name: filter_read_seq

Overview:
- Read-side address sequencer for the PE filter scratchpad; sits directly downstream of the filter spad's read port and drives its r_en/r_addr.
- Walks the stored filter row (filt_len = taps x channels words) once per output pixel, num_outs times, and tags each word for the MAC with valid/first/last markers.
- Waits for the spad fill to complete before the first read, and freezes on MAC back-pressure.

Parameters:
- MEM_DEPTH, 224, filter spad depth in words; must match the spad instance.
- ADDR_WIDTH, $clog2(MEM_DEPTH), spad address width.
- OUT_WIDTH, 8, width of the output-pixel reuse counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  asynchronous active-low reset: asserts when 0, releases synchronously to clk.
- start  input  1  one-cycle pulse; latches the configuration, accepted only in IDLE.
- filt_len  input  ADDR_WIDTH  words per filter pass; valid range 0..MEM_DEPTH.
- num_outs  input  OUT_WIDTH  number of passes (output pixels).
- spad_full  input  1  spad full flag (write pointer == spad_depth).
- mac_stall  input  1  MAC cannot accept a tap this cycle.
- r_en  output  1  spad read enable, registered.
- r_addr  output  ADDR_WIDTH  spad read address, registered.
- tap_valid  output  1  spad dout holds a tap for the MAC this cycle.
- tap_first  output  1  the valid tap is word 0 of a pass (MAC clears psum).
- tap_last  output  1  the valid tap is the final word of a pass (MAC emits psum).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of the job.

Behaviour:
- Reset: every output is 0, FSM in IDLE, all counters and latched config are 0.
- FSM states are IDLE, WAIT_FILL, RUN, DONE.
  - IDLE: start latches filt_len and num_outs. If either is 0, go to DONE; otherwise go to WAIT_FILL.
  - WAIT_FILL: stay until spad_full=1, then go to RUN.
  - RUN: on each non-stalled cycle, assert r_en with r_addr = word counter w. w runs 0..filt_len-1 and wraps to 0 while the pass counter p increments. The cycle that issues w=filt_len-1 with p=num_outs-1 is the final read; go to DONE on the next edge.
  - DONE: done=1 for exactly one cycle, then IDLE.
- r_en/r_addr change on posedge. The spad samples on the following negedge, so dout is valid from that negedge onward.
- tap_valid, tap_first and tap_last are the one-cycle-delayed copies of (r_en, w==0, w==filt_len-1). Fixed latency: read issue to tap_valid = 1 cycle.
- When filt_len=1, tap_first and tap_last are both high on every tap.
- Stall handling in RUN:
  - mac_stall=1 forces r_en=0 that cycle and freezes w and p; r_addr holds its value.
  - The delayed tap pipeline keeps its contents while stalled, so a tap already presented is held, not lost.
  - A stall on the final read delays the DONE transition.
- start outside IDLE is ignored.
- spad_full falling during RUN is ignored; the fill is already complete.
- Reset asserted mid-job: immediate return to the reset state; no done pulse.
- Arithmetic: w and p are unsigned. Wrap compares use the latched config, never the live inputs.
- filt_len > MEM_DEPTH is illegal; the block clamps it to MEM_DEPTH on latch.

Optional Feature:
- Macro: FILTER_READ_SEQ_STALL_CNT_EN.
- Defined:
  - adds output stall_cycles, 16 bits;
  - counts cycles with mac_stall=1 in RUN;
  - saturates at 16'hFFFF;
  - clears on start acceptance and on reset;
  - holds its value after done.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pe_pkg holds:
  - the FSM state enum: IDLE=2'd0, WAIT_FILL=2'd1, RUN=2'd2, DONE=2'd3;
  - the MEM_DEPTH default;
  - the OUT_WIDTH default.
- One sub-module, wrap_counter: parameterised width, enable input, limit input, count output, wrap pulse output.
- The block uses two wrap_counter instances chained: the w wrap enables p.

Test Plan:
- filt_len=3, num_outs=2, spad_full already 1, start -> addresses 0,1,2,0,1,2 on consecutive cycles. tap_first on taps 1 and 4, tap_last on taps 3 and 6; done pulses 2 cycles after the final read issue.
- spad_full held 0 for 10 cycles after start -> r_en stays 0 and busy=1 throughout. First r_addr=0 issues on the cycle after spad_full rises.
- filt_len=4, num_outs=1, mac_stall=1 for 3 cycles at w=2 -> r_addr stays 2 with r_en=0 and the tap for address 1 is held. Total run = 7 cycles. With FILTER_READ_SEQ_STALL_CNT_EN defined, stall_cycles=3.
- filt_len=0, or num_outs=0 with filt_len=5 -> no r_en pulse; done pulses in the 2nd cycle after start.
- filt_len=1, num_outs=3 -> three reads at address 0, each tap with tap_first=tap_last=1.
- reset driven low at the 4th read of filt_len=5, num_outs=2 -> all outputs 0 immediately, no done. A new start after release reruns from address 0.
